// File: rtl/dmem_ctrl_pkg.sv
// Shared types and defaults for the data-memory port controller.
package dmem_ctrl_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 12;
  localparam int IN_W_DEF   = 18;
  localparam int GCNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

endpackage

// File: rtl/dmem_ctrl_rr_arbiter.sv
// Rotating-priority arbiter: grants the first request at or after ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[PW'(j)]) begin
        any         = 1'b1;
        gnt[PW'(j)] = 1'b1;
        idx         = PW'(j);
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data-memory owner: host image load, then round-robin core access.
// Optional per-core grant counters enabled by DMEM_GRANT_CNT_EN.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int IN_W      = IN_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             load_base,
  input  logic [ADDR_W:0]               load_len,
  input  logic                          ld_valid,
  input  logic [IN_W-1:0]               ld_data,
  output logic                          ld_ready,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_gnt,
  output logic [NUM_CORES-1:0]          core_rvalid,
  output logic [DATA_W-1:0]             core_rdata,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy,
  output logic                          load_done,
  output logic                          ovf,
  output logic [NUM_CORES*GCNT_W-1:0]   grant_cnt
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [ADDR_W:0] ONE = 1;

  state_e                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [ADDR_W:0]        cnt_q, cnt_d;
  logic [ADDR_W:0]        len_q, len_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic                   ovf_q, ovf_d;
  logic [NUM_CORES-1:0]   rvalid_q, rvalid_d;

  logic [NUM_CORES-1:0]   arb_gnt;
  logic [PW-1:0]          arb_idx;
  logic                   arb_any;

  logic                   in_load;
  logic                   in_run;
  logic                   go_start;
  logic                   go_load;
  logic                   run_go;
  logic                   accept;
  logic                   hi_bits;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

  rr_arbiter #(
    .N  (NUM_CORES),
    .PW (PW)
  ) u_arb (
    .req (core_req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  generate
    if (IN_W > DATA_W) begin : g_hi
      assign hi_bits = |ld_data[IN_W-1:DATA_W];
    end else begin : g_nohi
      assign hi_bits = 1'b0;
    end
  endgenerate

  assign in_load  = (state_q == LOAD);
  assign in_run   = (state_q == RUN);
  assign go_start = start & ((state_q == IDLE) | in_run);
  assign go_load  = go_start & (load_len != '0);
  assign run_go   = in_run & ~start;
  assign accept   = in_load & ld_valid;

  assign ld_ready    = in_load;
  assign busy        = in_load;
  assign core_gnt    = run_go ? arb_gnt : '0;
  assign core_rvalid = rvalid_q;
  assign core_rdata  = mem_rdata;
  assign ovf         = ovf_q;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (arb_gnt[i]) begin
        sel_we    = core_we[i];
        sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    base_d    = base_q;
    ovf_d     = ovf_q;
    rvalid_d  = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    load_done = 1'b0;
    if (go_start) begin
      ovf_d = 1'b0;
      if (go_load) begin
        state_d = LOAD;
        cnt_d   = '0;
        len_d   = load_len;
        base_d  = load_base;
      end else begin
        state_d = RUN;
      end
    end else if (accept) begin
      mem_we    = 1'b1;
      mem_addr  = base_q + cnt_q[ADDR_W-1:0];
      mem_wdata = ld_data[DATA_W-1:0];
      cnt_d     = cnt_q + ONE;
      if (hi_bits) ovf_d = 1'b1;
      if (cnt_q == len_q - ONE) begin
        load_done = 1'b1;
        state_d   = RUN;
      end
    end else if (run_go && arb_any) begin
      mem_we    = sel_we;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      rvalid_d  = sel_we ? '0 : arb_gnt;
      ptr_d     = (arb_idx == PW'(NUM_CORES - 1)) ? '0 : arb_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      base_q   <= '0;
      ovf_q    <= 1'b0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      base_q   <= base_d;
      ovf_q    <= ovf_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef DMEM_GRANT_CNT_EN
  logic [NUM_CORES*GCNT_W-1:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    if (go_load) begin
      gcnt_d = '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_gnt[i] && (gcnt_q[i*GCNT_W +: GCNT_W] != '1)) begin
          gcnt_d[i*GCNT_W +: GCNT_W] =
            gcnt_q[i*GCNT_W +: GCNT_W] + GCNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gcnt_q <= '0;
    else     gcnt_q <= gcnt_d;
  end

  assign grant_cnt = gcnt_q;
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl against a behavioural model of load/run access.
module tb_dmem_ctrl;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int IW = 18;
  localparam int MS = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     load_base;
  logic [AW:0]       load_len;
  logic              ld_valid;
  logic [IW-1:0]     ld_data;
  logic              ld_ready;
  logic [N-1:0]      core_req;
  logic [N-1:0]      core_we;
  logic [N*AW-1:0]   core_addr;
  logic [N*DW-1:0]   core_wdata;
  logic [N-1:0]      core_gnt;
  logic [N-1:0]      core_rvalid;
  logic [DW-1:0]     core_rdata;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata = '0;
  logic              busy;
  logic              load_done;
  logic              ovf;
  logic [N*16-1:0]   grant_cnt;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .NUM_CORES (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .IN_W      (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .load_base   (load_base),
    .load_len    (load_len),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .load_done   (load_done),
    .ovf         (ovf),
    .grant_cnt   (grant_cnt)
  );

  // Stand-in for datamemory: one-cycle synchronous read.
  logic [DW-1:0] dmem [MS];
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr] <= mem_wdata;
    mem_rdata <= dmem[mem_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Behavioural model: mode 0 idle, 1 load, 2 run.
  int            m_mode = 0;
  int            m_base, m_len, m_n;
  int            m_ptr  = 0;
  int            m_pend = -1;
  logic [DW-1:0] m_pdata;
  int            m_gcnt [N];
  bit            m_ovf  = 0;
  logic [DW-1:0] exp_mem [MS];
  logic [N-1:0]  m_gnt  = '0;
  int            glog [$];
  logic [DW-1:0] last_rd2 = '0;

  initial begin
    for (int a = 0; a < MS; a++) begin
      dmem[a]    = '0;
      exp_mem[a] = '0;
    end
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
  end

  always @(negedge clk) begin
    logic [N-1:0]    e_gnt, e_rv;
    logic            e_we, e_rdy, e_done, e_ovf;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wd;
    logic [N*16-1:0] e_gc;
    int              nxt_pend;
    bit              found;
    e_gnt = '0; e_rv = '0; e_we = 0; e_rdy = 0; e_done = 0;
    e_addr = '0; e_wd = '0; e_gc = '0; nxt_pend = -1; found = 0;
    e_ovf = m_ovf;
`ifdef DMEM_GRANT_CNT_EN
    for (int i = 0; i < N; i++) e_gc[i*16 +: 16] = 16'(m_gcnt[i]);
`endif
    if (rst) begin
      e_ovf  = 0;
      e_gc   = '0;
      m_mode = 0; m_ptr = 0; m_ovf = 0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    end else begin
      if (m_pend >= 0) begin
        e_rv[m_pend] = 1'b1;
        chk("core_rdata", 64'(core_rdata), 64'(m_pdata));
        if (m_pend == 2) last_rd2 = core_rdata;
      end
      if (m_mode == 1) begin
        e_rdy = 1;
        if (ld_valid) begin
          e_we   = 1;
          e_addr = AW'((m_base + m_n) % MS);
          e_wd   = ld_data[DW-1:0];
          exp_mem[e_addr] = e_wd;
          if (ld_data[IW-1:DW] != 0) m_ovf = 1;
          m_n++;
          if (m_n == m_len) begin
            e_done = 1;
            m_mode = 2;
          end
        end
      end else if (start) begin
        m_ovf = 0;
        if (load_len != 0) begin
          m_mode = 1; m_base = int'(load_base);
          m_len  = int'(load_len); m_n = 0;
          for (int i = 0; i < N; i++) m_gcnt[i] = 0;
        end else begin
          m_mode = 2;
        end
      end else if (m_mode == 2) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (!found && core_req[c]) begin
            found    = 1;
            e_gnt[c] = 1'b1;
            e_we     = core_we[c];
            e_addr   = core_addr[c*AW +: AW];
            e_wd     = core_wdata[c*DW +: DW];
            if (e_we) exp_mem[e_addr] = e_wd;
            else begin
              nxt_pend = c;
              m_pdata  = exp_mem[e_addr];
            end
            m_ptr = (c + 1) % N;
            if (m_gcnt[c] < 65535) m_gcnt[c]++;
            glog.push_back(c);
          end
        end
      end
    end
    m_pend = rst ? -1 : nxt_pend;
    m_gnt  = e_gnt;
    chk("core_gnt",    64'(core_gnt),    64'(e_gnt));
    chk("core_rvalid", 64'(core_rvalid), 64'(e_rv));
    chk("mem_we",      64'(mem_we),      64'(e_we));
    chk("mem_addr",    64'(mem_addr),    64'(e_addr));
    chk("mem_wdata",   64'(mem_wdata),   64'(e_wd));
    chk("ld_ready",    64'(ld_ready),    64'(e_rdy));
    chk("busy",        64'(busy),        64'(e_rdy));
    chk("load_done",   64'(load_done),   64'(e_done));
    chk("ovf",         64'(ovf),         64'(e_ovf));
    chk("grant_cnt",   grant_cnt,        e_gc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [IW-1:0] ldw [16];

  task automatic do_load(input int base, input int len);
    start     = 1;
    load_base = AW'(base);
    load_len  = (AW+1)'(len);
    tick();
    start = 0;
    for (int w = 0; w < len; w++) begin
      ld_valid = 0;
      repeat ($urandom_range(0, 2)) tick();
      ld_valid = 1;
      ld_data  = ldw[w];
      tick();
    end
    ld_valid = 0;
    tick();
  endtask

  initial begin
    int exp_g [5];
    int diffs;
    int budget;
    exp_g = '{0, 1, 2, 3, 0};
    rst = 1; start = 0; load_base = '0; load_len = '0;
    ld_valid = 0; ld_data = '0; core_req = '0; core_we = '0;
    core_addr = '0; core_wdata = '0;
    repeat (3) tick();
    rst = 0;
    tick();

    ldw[0] = 1; ldw[1] = 2; ldw[2] = 1; ldw[3] = 2;
    do_load(8, 4);
    chk("t1_mem8",  64'(dmem[8]),  64'd1);
    chk("t1_mem9",  64'(dmem[9]),  64'd2);
    chk("t1_mem10", 64'(dmem[10]), 64'd1);
    chk("t1_mem11", 64'(dmem[11]), 64'd2);

    ldw[0] = 18'h00AAA; ldw[1] = 18'h00BBB;
    ldw[2] = 18'h00CCC; ldw[3] = 18'h00DDD;
    do_load(4094, 4);
    chk("t2_mem4094", 64'(dmem[4094]), 64'hAAA);
    chk("t2_mem4095", 64'(dmem[4095]), 64'hBBB);
    chk("t2_mem0",    64'(dmem[0]),    64'hCCC);
    chk("t2_mem1",    64'(dmem[1]),    64'hDDD);
    chk("t2_mem2",    64'(dmem[2]),    64'h0);
    chk("t2_mem4093", 64'(dmem[4093]), 64'h0);

    ldw[0] = 18'h01005; ldw[1] = 18'h00ABC;
    do_load(516, 2);
    chk("t3_mem516", 64'(dmem[516]), 64'h005);
    chk("t3_ovf",    64'(ovf),       64'd1);
    repeat (3) tick();
    chk("t3_ovf_sticky", 64'(ovf), 64'd1);

    glog.delete();
    core_we = '0;
    for (int i = 0; i < N; i++) core_addr[i*AW +: AW] = AW'(i * 10);
    core_req = 4'hF;
    repeat (5) tick();
    core_req = '0;
    tick();
    chk("t4_glog_n", 64'(glog.size()), 64'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++)
      chk("t4_gorder", 64'(glog[i]), 64'(exp_g[i]));
    core_addr[2*AW +: AW] = AW'(516);
    core_req = 4'b0100;
    tick();
    core_req = '0;
    tick();
    tick();
    chk("t4_rd516", 64'(last_rd2), 64'h005);

    ldw[0] = 18'h00111; ldw[1] = 18'h00222;
    core_req  = 4'hF;
    start     = 1;
    load_base = AW'(200);
    load_len  = 13'd6;
    tick();
    start    = 0;
    ld_valid = 1;
    ld_data  = ldw[0];
    tick();
    ld_data = ldw[1];
    rst     = 1;
    tick();
    rst = 0; ld_valid = 0; core_req = '0;
    repeat (3) tick();
    chk("t5_mem200", 64'(dmem[200]), 64'h111);
    chk("t5_mem201", 64'(dmem[201]), 64'h0);
    chk("t5_ovf",    64'(ovf),       64'd0);

    start = 1; load_len = '0;
    tick();
    start = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!core_req[i] || m_gnt[i]) begin
          core_req[i] = ($urandom_range(0, 2) != 0);
          core_we[i]  = 1'($urandom);
          core_addr[i*AW +: AW]  = AW'($urandom_range(0, 63));
          core_wdata[i*DW +: DW] = DW'($urandom);
        end
      end
      ld_valid  = 1'($urandom);
      ld_data   = IW'($urandom) & ($urandom_range(0, 3) == 0 ? 18'h3FFFF
                                                             : 18'h00FFF);
      start     = ($urandom_range(0, 99) == 0);
      load_base = AW'($urandom_range(0, 63));
      load_len  = (AW+1)'($urandom_range(0, 5));
      tick();
    end
    start = 0; core_req = '0; ld_valid = 1;
    budget = 0;
    while (m_mode == 1 && budget < 20) begin
      tick();
      budget++;
    end
    chk("drain_load", 64'(m_mode == 1), 64'd0);
    ld_valid = 0;
    tick();

`ifdef DMEM_GRANT_CNT_EN
    core_req = 4'b0001; core_we = 4'b0001;
    core_addr[AW-1:0] = AW'(5); core_wdata[DW-1:0] = DW'(1);
    repeat (70000) tick();
    core_req = '0;
    tick();
    chk("t6_sat", 64'(grant_cnt[15:0]), 64'hFFFF);
`else
    core_req = 4'b0001; core_we = 4'b0001;
    repeat (50) tick();
    core_req = '0;
    tick();
    chk("t6_zero", grant_cnt, 64'h0);
`endif

    diffs = 0;
    for (int a = 0; a < MS; a++)
      if (dmem[a] !== exp_mem[a]) diffs++;
    chk("mem_image", 64'(diffs), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
